amp_seq_mute: RTL and testbench

Amplifier power sequencer and soft-mute stage between the equalizer engine output and the PDM speaker driver.
- Owns the amplifier sht_dwn pin: 5 ms power-up hold, Flt_n fault debounce, bounded auto-retry, latched lockout.
- Gates and ramps the 16-bit stereo audio so the amplifiers never see a step on enable or after a fault recovery.

---
 rtl/amp_seq_mute.sv | 198 +++++++++++++++++++
 tb/tb_amp_seq_mute.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/amp_seq_mute.sv
// Amplifier power sequencer and soft-mute gate between the EQ engine
// and the PDM speaker driver.
module amp_seq_mute #(
    parameter int SHTDWN_CYC = 250000,
    parameter int FLT_DB_CYC = 5000,
    parameter int MAX_RETRY  = 3,
    parameter int STABLE_CYC = 50000000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               Flt_n,
    input  logic               clr_fault,
    input  logic               vld,
    input  logic signed [15:0] aud_in_lft,
    input  logic signed [15:0] aud_in_rght,
    output logic               sht_dwn,
    output logic signed [15:0] aud_out_lft,
    output logic signed [15:0] aud_out_rght,
    output logic               vld_out,
    output logic               amp_ok,
    output logic               fault_latched
);

    localparam int TW = $clog2(SHTDWN_CYC + 1);
    localparam int DW = $clog2(FLT_DB_CYC + 1);
    localparam int SW = $clog2(STABLE_CYC + 1);
    localparam int RW = $clog2(MAX_RETRY + 1);

    localparam logic [TW-1:0] TM_LAST = TW'(SHTDWN_CYC - 1);
    localparam logic [DW-1:0] DB_LAST = DW'(FLT_DB_CYC - 1);
    localparam logic [SW-1:0] SB_LAST = SW'(STABLE_CYC - 1);
    localparam logic [RW-1:0] RT_MAX  = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_SHDN,
        ST_RAMP,
        ST_RUN,
        ST_FAULT,
        ST_LOCK
    } state_t;

    state_t state, state_n;

    logic          flt_s1, flt_s2;
    logic [DW-1:0] db_cnt;
    logic [TW-1:0] timer;
    logic [SW-1:0] stab_cnt;
    logic [RW-1:0] retry;
    logic [8:0]    gain;
    logic          live, fault;

    assign live  = (state == ST_RAMP) || (state == ST_RUN);
    assign fault = live && !flt_s2 && (db_cnt == DB_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flt_s1 <= 1'b1;
            flt_s2 <= 1'b1;
        end else begin
            flt_s1 <= Flt_n;
            flt_s2 <= flt_s1;
        end
    end

    // Debounce only runs while the amp is powered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            db_cnt <= '0;
        else if (!live || flt_s2 || fault)
            db_cnt <= '0;
        else
            db_cnt <= db_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_SHDN;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            ST_SHDN: begin
                if (timer == TM_LAST)
                    state_n = ST_RAMP;
            end
            ST_RAMP: begin
                if (fault)
                    state_n = ST_FAULT;
                else if (vld && gain == 9'd255)
                    state_n = ST_RUN;
            end
            ST_RUN: begin
                if (fault)
                    state_n = ST_FAULT;
            end
            ST_FAULT: begin
                if (retry == RT_MAX)
                    state_n = ST_LOCK;
                else
                    state_n = ST_SHDN;
            end
            ST_LOCK: begin
                if (clr_fault)
                    state_n = ST_SHDN;
            end
            default: state_n = ST_SHDN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            timer <= '0;
        else if (state == ST_SHDN && timer != TM_LAST)
            timer <= timer + 1'b1;
        else
            timer <= '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stab_cnt <= '0;
        end else if (state == ST_RUN && !fault) begin
            if (stab_cnt != SB_LAST)
                stab_cnt <= stab_cnt + 1'b1;
        end else begin
            stab_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            retry <= '0;
        else if (fault)
            retry <= retry + 1'b1;
        else if (state == ST_RUN && stab_cnt == SB_LAST)
            retry <= '0;
        else if (state == ST_LOCK && clr_fault)
            retry <= '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gain <= '0;
        end else begin
            unique case (state)
                ST_RAMP: begin
                    if (fault)
                        gain <= '0;
                    else if (vld)
                        gain <= gain + 9'd1;
                end
                ST_RUN:  gain <= fault ? 9'd0 : 9'd256;
                default: gain <= '0;
            endcase
        end
    end

    // Status pins decode the next state so they move with the transition
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sht_dwn       <= 1'b1;
            amp_ok        <= 1'b0;
            fault_latched <= 1'b0;
        end else begin
            sht_dwn       <= !(state_n == ST_RAMP ||
                               state_n == ST_RUN);
            amp_ok        <= (state_n == ST_RUN);
            fault_latched <= (state_n == ST_LOCK);
        end
    end

    logic [8:0]         g_eff;
    logic signed [9:0]  g_s;
    logic signed [23:0] p_l, p_r;

    assign g_eff = fault ? 9'd0 : gain;
    assign g_s   = signed'({1'b0, g_eff});
    assign p_l   = 24'(aud_in_lft) * 24'(g_s);
    assign p_r   = 24'(aud_in_rght) * 24'(g_s);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aud_out_lft  <= '0;
            aud_out_rght <= '0;
            vld_out      <= 1'b0;
        end else begin
            vld_out <= vld;
            if (vld) begin
                aud_out_lft  <= 16'(p_l >>> 8);
                aud_out_rght <= 16'(p_r >>> 8);
            end
        end
    end

endmodule

// File: tb/tb_amp_seq_mute.sv
// Bench for amp_seq_mute: scaled-down timing, table vectors,
// directed sequences and a random run against a behavioural model.
module tb_amp_seq_mute;

    localparam int S  = 40;
    localparam int DB = 6;
    localparam int MR = 3;
    localparam int ST = 2000;

    localparam int M_OFF  = 0;
    localparam int M_RAMP = 1;
    localparam int M_RUN  = 2;
    localparam int M_FLT  = 3;
    localparam int M_LOCK = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic               Flt_n;
    logic               clr_fault;
    logic               vld;
    logic signed [15:0] in_l, in_r;
    logic               sht_dwn;
    logic signed [15:0] out_l, out_r;
    logic               vld_out;
    logic               amp_ok;
    logic               fault_latched;

    amp_seq_mute #(
        .SHTDWN_CYC(S),
        .FLT_DB_CYC(DB),
        .MAX_RETRY (MR),
        .STABLE_CYC(ST)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .Flt_n        (Flt_n),
        .clr_fault    (clr_fault),
        .vld          (vld),
        .aud_in_lft   (in_l),
        .aud_in_rght  (in_r),
        .sht_dwn      (sht_dwn),
        .aud_out_lft  (out_l),
        .aud_out_rght (out_r),
        .vld_out      (vld_out),
        .amp_ok       (amp_ok),
        .fault_latched(fault_latched)
    );

    int checks = 0;
    int errors = 0;

    int          m_mode, m_hold, m_gain;
    int          m_low, m_retry, m_run;
    logic        m_s1, m_s2, m_vo;
    logic [15:0] m_ol, m_or;

    function automatic logic [15:0] scale(
        logic signed [15:0] x, int g);
        int p;
        p = int'(x) * g;
        p = p >>> 8;
        return p[15:0];
    endfunction

    task automatic model_reset();
        m_mode  = M_OFF;
        m_hold  = 0;
        m_gain  = 0;
        m_low   = 0;
        m_retry = 0;
        m_run   = 0;
        m_s1    = 1'b1;
        m_s2    = 1'b1;
        m_vo    = 1'b0;
        m_ol    = '0;
        m_or    = '0;
    endtask

    task automatic model_step();
        bit live, flt;
        int g;
        live = (m_mode == M_RAMP) || (m_mode == M_RUN);
        flt  = 1'b0;
        if (live && !m_s2) begin
            m_low++;
            if (m_low >= DB) begin
                flt   = 1'b1;
                m_low = 0;
            end
        end else begin
            m_low = 0;
        end
        g    = flt ? 0 : m_gain;
        m_vo = vld;
        if (vld) begin
            m_ol = scale(in_l, g);
            m_or = scale(in_r, g);
        end
        if (flt) begin
            m_mode = M_FLT;
            m_gain = 0;
            m_retry++;
            m_run  = 0;
        end else begin
            case (m_mode)
                M_OFF: begin
                    m_hold++;
                    if (m_hold == S) begin
                        m_mode = M_RAMP;
                        m_hold = 0;
                    end
                end
                M_RAMP: begin
                    if (vld) begin
                        m_gain++;
                        if (m_gain == 256) begin
                            m_mode = M_RUN;
                            m_run  = 0;
                        end
                    end
                end
                M_RUN: begin
                    if (m_run >= ST - 1)
                        m_retry = 0;
                    m_run++;
                end
                M_FLT: begin
                    if (m_retry == MR) begin
                        m_mode = M_LOCK;
                    end else begin
                        m_mode = M_OFF;
                        m_hold = 0;
                    end
                end
                M_LOCK: begin
                    if (clr_fault) begin
                        m_mode  = M_OFF;
                        m_hold  = 0;
                        m_retry = 0;
                    end
                end
                default: ;
            endcase
        end
        m_s2 = m_s1;
        m_s1 = Flt_n;
    endtask

    function automatic logic [35:0] exp_vec();
        logic on;
        on = (m_mode == M_RAMP) || (m_mode == M_RUN);
        return {!on, m_mode == M_RUN, m_mode == M_LOCK,
                m_vo, m_ol, m_or};
    endfunction

    function automatic logic [35:0] act_vec();
        return {sht_dwn, amp_ok, fault_latched,
                vld_out, out_l, out_r};
    endfunction

    task automatic check(string name,
                         logic [35:0] act,
                         logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n)
            model_step();
        #1;
        check("cycle", act_vec(), exp_vec());
    endtask

    task automatic step_vld(input logic signed [15:0] l,
                            input logic signed [15:0] r,
                            output logic [15:0] o);
        vld  = 1'b1;
        in_l = l;
        in_r = r;
        tick();
        o    = out_l;
        vld  = 1'b0;
        tick();
    endtask

    task automatic wait_mode(int m, int budget, string name);
        int n;
        logic [15:0] d;
        n = 0;
        while (m_mode != m && n < budget) begin
            step_vld(16'sh0100, -16'sh0100, d);
            n++;
        end
        if (m_mode != m) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout after %0d steps", name, n);
        end
    endtask

    task automatic count_hold(string name);
        int n;
        n = 0;
        while (sht_dwn && n < S + 20) begin
            tick();
            n++;
        end
        check(name, 36'(n), 36'(S));
    endtask

    typedef struct {
        logic [15:0] din;
        int          gain;
        logic [15:0] dout;
    } vec_t;

    vec_t vt[9];

    initial begin
        int          n, rise, burst;
        logic [15:0] o;

        vt[0] = '{16'h4000,   0, 16'h0000};
        vt[1] = '{16'h8000,   1, 16'hFF80};
        vt[2] = '{16'hFFFF,   2, 16'hFFFF};
        vt[3] = '{16'h4000, 127, 16'h1FC0};
        vt[4] = '{16'h0100, 128, 16'h0080};
        vt[5] = '{16'h7FFF, 200, 16'h63FF};
        vt[6] = '{16'h8000, 255, 16'h8080};
        vt[7] = '{16'h8000, 256, 16'h8000};
        vt[8] = '{16'h4000, 256, 16'h4000};

        rst_n     = 1'b0;
        Flt_n     = 1'b1;
        clr_fault = 1'b0;
        vld       = 1'b0;
        in_l      = '0;
        in_r      = '0;
        model_reset();
        #23;
        check("reset_state", act_vec(), 36'h8_0000_0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        count_hold("hold_after_reset");

        for (int i = 0; i < 9; i++) begin
            n = 0;
            while (m_gain < vt[i].gain && n < 600) begin
                step_vld(16'sh0100, 16'sh0100, o);
                n++;
            end
            step_vld(vt[i].din, ~vt[i].din, o);
            check($sformatf("vec%0d_g%0d", i, vt[i].gain),
                  36'(o), 36'(vt[i].dout));
        end
        check("amp_ok_run", 36'(amp_ok), 36'(1));

        Flt_n = 1'b0;
        repeat (DB - 1) tick();
        Flt_n = 1'b1;
        repeat (6) tick();
        check("short_glitch", 36'({sht_dwn, amp_ok}), 36'(1));

        rise  = 0;
        Flt_n = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (sht_dwn && rise == 0)
                rise = i;
            if (i == 10)
                Flt_n = 1'b1;
        end
        check("fault_latency", 36'(rise), 36'(DB + 2));
        step_vld(16'sh4000, 16'sh4000, o);
        check("muted_out", 36'(o), 36'(0));
        wait_mode(M_RUN, 600, "recover_run");

        repeat (ST + 10) tick();
        for (int k = 1; k <= 3; k++) begin
            wait_mode(M_RUN, 600, "retry_run");
            Flt_n = 1'b0;
            repeat (10) tick();
            Flt_n = 1'b1;
            tick();
            check($sformatf("lockout_after_%0d", k),
                  36'(fault_latched), 36'(k == 3));
        end
        n = 0;
        repeat (300) begin
            tick();
            if (sht_dwn)
                n++;
        end
        check("lockout_hold", 36'(n), 36'(300));
        clr_fault = 1'b1;
        tick();
        clr_fault = 1'b0;
        check("clr_release", 36'({sht_dwn, fault_latched}),
              36'(2));
        count_hold("hold_after_clr");
        wait_mode(M_RUN, 600, "clr_run");
        clr_fault = 1'b1;
        tick();
        clr_fault = 1'b0;
        tick();
        check("clr_in_run", 36'({sht_dwn, amp_ok}), 36'(1));

        Flt_n = 1'b0;
        repeat (10) tick();
        Flt_n = 1'b1;
        n = 0;
        while (!(m_mode == M_RAMP && m_gain == 100) && n < 800) begin
            step_vld(16'sh2000, -16'sh2000, o);
            n++;
        end
        check("ramp_g100", 36'(m_gain), 36'(100));
        rst_n = 1'b0;
        #1;
        check("async_reset", act_vec(), 36'h8_0000_0000);
        model_reset();
        repeat (3) tick();
        rst_n = 1'b1;
        count_hold("hold_after_midreset");

        burst = 0;
        for (int c = 0; c < 20000; c++) begin
            vld       = ($urandom % 3) == 0;
            in_l      = 16'($urandom);
            in_r      = 16'($urandom);
            clr_fault = ($urandom % 60) == 0;
            if (burst > 0) begin
                Flt_n = 1'b0;
                burst--;
            end else begin
                Flt_n = 1'b1;
                if (($urandom % 150) == 0)
                    burst = $urandom_range(1, 2 * DB);
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
